// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C write-burst engine.
//   state_t        : sequencer states
//   PH_PER_BIT     : PT_CK phases per SCL period
//   BITS_PER_BYTE  : eight data bits plus the ACK slot
//   clamp_nbytes() : limits a requested payload count to the supported maximum
//   burst_cycles() : nominal START-entry to END_OK-high time of a fully ACKed burst
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        START,
        B_LO,
        B_SET,
        B_HI,
        B_END,
        P0,
        P1,
        P2,
        DONE
    } state_t;

    localparam int PH_PER_BIT    = 4;
    localparam int BITS_PER_BYTE = 9;

    function automatic int clamp_nbytes(input int n, input int max_n);
        return (n > max_n) ? max_n : n;
    endfunction

    // START (1) + address/pointer/payload bytes + STOP (3) + DONE (1)
    function automatic int burst_cycles(input int n);
        return 1 + PH_PER_BIT * BITS_PER_BYTE * (2 + n) + 3 + 1;
    endfunction

endpackage

// File: rtl/i2c_write_burst_if.sv
// i2c_write_burst_if: request/status/bus bundle between the sensor-control
// sequencer plus pad logic (master modport) and the write engine (slave modport).
//   GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES : burst request
//   SDAI (and SCLI when I2C_WB_CLK_STRETCH_EN) : sampled pad levels
//   SDAO, SCLO                           : open-drain drive, 1 = release
//   END_OK, ACK_OK, NACK_ERR, BYTE_CNT   : burst status
interface i2c_write_burst_if #(
    parameter int MAX_BYTES = 4,
    parameter int CW        = $clog2(MAX_BYTES + 1)
);

    logic                   GO;
    logic [7:0]             SLAVE_ADDRESS;
    logic [7:0]             POINTER;
    logic [8*MAX_BYTES-1:0] DATA;
    logic [CW-1:0]          NBYTES;
    logic                   SDAI;
    logic                   SDAO;
    logic                   SCLO;
    logic                   END_OK;
    logic                   ACK_OK;
    logic                   NACK_ERR;
    logic [CW:0]            BYTE_CNT;
`ifdef I2C_WB_CLK_STRETCH_EN
    logic                   SCLI;

    modport master (
        output GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, SDAI, SCLI,
        input  SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_CNT
    );

    modport slave (
        input  GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, SDAI, SCLI,
        output SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_CNT
    );
`else
    modport master (
        output GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, SDAI,
        input  SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_CNT
    );

    modport slave (
        input  GO, SLAVE_ADDRESS, POINTER, DATA, NBYTES, SDAI,
        output SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_CNT
    );
`endif

endinterface

// File: rtl/i2c_byte_tx.sv
// i2c_byte_tx: 9-bit transmit shifter (byte followed by a released ACK bit)
// with a bit counter.
//   clk_sys : PT_CK
//   rst_b   : synchronous active-low reset
//   load    : capture {byte_in, 1} and clear the bit counter
//   shift   : advance the shifter by one bit (MSB leaves first)
//   bit_inc : count one completed SCL high phase
//   msb     : bit to drive on SDA next
//   done    : all nine bit slots of the current byte have been clocked
module i2c_byte_tx
    import i2c_pkg::*;
(
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic       load,
    input  logic       shift,
    input  logic       bit_inc,
    input  logic [7:0] byte_in,
    output logic       msb,
    output logic       done
);

    logic [8:0] shreg;
    logic [3:0] bit_cnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            shreg   <= '1;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= {byte_in, 1'b1};
            bit_cnt <= '0;
        end else begin
            if (shift) begin
                shreg <= {shreg[7:0], 1'b1};
            end
            if (bit_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign msb  = shreg[8];
    assign done = (bit_cnt == 4'(BITS_PER_BYTE));

endmodule

// File: rtl/i2c_write_burst.sv
// i2c_write_burst: I2C master write engine. One GO handshake (high in IDLE,
// then low) sends START, address byte, pointer byte, 0..MAX_BYTES payload
// bytes and STOP, checking ACK after every byte; a NACK skips to STOP.
//   PT_CK   : bit-phase clock, four phases per SCL period
//   RESET_N : synchronous active-low reset; abandons the bus with no STOP
//   bus     : i2c_write_burst_if slave modport (request, pads, status)
// Build option: I2C_WB_CLK_STRETCH_EN adds bus.SCLI; while SCL is released
// and SCLI reads low, the engine waits before sampling ACK / completing STOP.
//
// state | meaning
// IDLE  | bus released, waiting for GO high
// ARM   | waiting for GO low; request latched on exit
// START | SDA low with SCL high, address byte loaded
// B_LO  | SCL low
// B_SET | drive next bit on SDA
// B_HI  | release SCL, count bit
// B_END | SCL low again; ACK sampled after bit 9
// P0    | SDA low, SCL low
// P1    | release SCL
// P2    | release SDA (STOP)
// DONE  | publish END_OK / ACK_OK
module i2c_write_burst
    import i2c_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int CW        = $clog2(MAX_BYTES + 1)
) (
    input  logic             PT_CK,
    input  logic             RESET_N,
    i2c_write_burst_if.slave bus
);

    state_t                 state;
    logic [7:0]             addr_l;
    logic [7:0]             ptr_l;
    logic [8*MAX_BYTES-1:0] data_l;
    logic [CW-1:0]          nbytes_l;

    logic                   sdao;
    logic                   sclo;
    logic                   end_ok;
    logic                   ack_ok;
    logic                   nack_err;
    logic [CW:0]            byte_cnt;

    logic [CW:0]            cnt_next;
    logic                   more;
    logic [7:0]             next_byte;
    logic                   scl_ok;

    logic                   tx_load;
    logic                   tx_shift;
    logic                   tx_inc;
    logic [7:0]             tx_byte;
    logic                   tx_msb;
    logic                   tx_done;

    // SCLO is registered, so the pad is actually released during B_END and P2;
    // that is where a stretching slave is observed.
`ifdef I2C_WB_CLK_STRETCH_EN
    assign scl_ok = bus.SCLI;
`else
    assign scl_ok = 1'b1;
`endif

    // byte_cnt counts ACKed bytes, so cnt_next is also the index of the byte
    // to load next: 1 = pointer, 2.. = payload.
    always_comb begin
        cnt_next  = byte_cnt + 1'b1;
        more      = cnt_next < ((CW+1)'(nbytes_l) + (CW+1)'(2));
        next_byte = ptr_l;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (cnt_next == (CW+1)'(k + 2)) begin
                next_byte = data_l[8*k +: 8];
            end
        end
    end

    always_comb begin
        tx_load  = (state == START) ||
                   ((state == B_END) && scl_ok && tx_done && !bus.SDAI && more);
        tx_byte  = (state == START) ? addr_l : next_byte;
        tx_shift = (state == B_SET);
        tx_inc   = (state == B_HI);
    end

    i2c_byte_tx u_byte_tx (
        .clk_sys (PT_CK),
        .rst_b   (RESET_N),
        .load    (tx_load),
        .shift   (tx_shift),
        .bit_inc (tx_inc),
        .byte_in (tx_byte),
        .msb     (tx_msb),
        .done    (tx_done)
    );

    always_ff @(posedge PT_CK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            sdao     <= 1'b1;
            sclo     <= 1'b1;
            end_ok   <= 1'b1;
            ack_ok   <= 1'b0;
            nack_err <= 1'b0;
            byte_cnt <= '0;
            addr_l   <= '0;
            ptr_l    <= '0;
            data_l   <= '0;
            nbytes_l <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sdao <= 1'b1;
                    sclo <= 1'b1;
                    if (bus.GO) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (!bus.GO) begin
                        addr_l   <= bus.SLAVE_ADDRESS;
                        ptr_l    <= bus.POINTER;
                        data_l   <= bus.DATA;
                        nbytes_l <= CW'(clamp_nbytes(int'(bus.NBYTES), MAX_BYTES));
                        end_ok   <= 1'b0;
                        ack_ok   <= 1'b0;
                        nack_err <= 1'b0;
                        byte_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    sdao  <= 1'b0;
                    sclo  <= 1'b1;
                    state <= B_LO;
                end
                B_LO: begin
                    sclo  <= 1'b0;
                    state <= B_SET;
                end
                B_SET: begin
                    sdao  <= tx_msb;
                    state <= B_HI;
                end
                B_HI: begin
                    sclo  <= 1'b1;
                    state <= B_END;
                end
                B_END: begin
                    if (scl_ok) begin
                        sclo <= 1'b0;
                        if (!tx_done) begin
                            state <= B_LO;
                        end else if (bus.SDAI) begin
                            nack_err <= 1'b1;
                            ack_ok   <= 1'b0;
                            state    <= P0;
                        end else begin
                            byte_cnt <= cnt_next;
                            state    <= more ? B_LO : P0;
                        end
                    end
                end
                P0: begin
                    sdao  <= 1'b0;
                    sclo  <= 1'b0;
                    state <= P1;
                end
                P1: begin
                    sclo  <= 1'b1;
                    state <= P2;
                end
                P2: begin
                    if (scl_ok) begin
                        sdao  <= 1'b1;
                        sclo  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    end_ok <= 1'b1;
                    ack_ok <= !nack_err;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SDAO     = sdao;
    assign bus.SCLO     = sclo;
    assign bus.END_OK   = end_ok;
    assign bus.ACK_OK   = ack_ok;
    assign bus.NACK_ERR = nack_err;
    assign bus.BYTE_CNT = byte_cnt;

endmodule

// File: tb/tb_i2c_write_burst.sv
module tb_i2c_write_burst;

    localparam int MAXB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   t_start = 0;
    int   stops   = 0;
    int   nack_byte = 0;
    logic [7:0] byte_q [$];

    i2c_write_burst_if #(.MAX_BYTES(MAXB)) bus ();

    i2c_write_burst #(.MAX_BYTES(MAXB)) dut (
        .PT_CK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input int n, input logic [47:0] exp);
        logic [7:0] o;
        check({tag, "_nbytes"}, byte_q.size(), n);
        for (int i = 0; i < n; i++) begin
            o = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(o), 32'(exp[8*i +: 8]));
        end
    endtask

    task automatic start_burst(input logic [7:0] a, input logic [7:0] p, input logic [31:0] dat,
                               input logic [2:0] nb, input int hold, output int dly);
        bit seen;
        int t_go;
        bus.SLAVE_ADDRESS = a;
        bus.POINTER       = p;
        bus.DATA          = dat;
        bus.NBYTES        = nb;
        bus.GO            = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.GO = 1'b0;
        t_go   = cyc;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = !bus.END_OK;
        end
        t_start = cyc;
        dly     = seen ? cyc - t_go : -1;
    endtask

    task automatic wait_done(output int dur);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.END_OK;
        end
        dur = seen ? cyc - t_start : -1;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] cnt);
        check({tag, "_sdao"},   32'(bus.SDAO),     32'd1);
        check({tag, "_sclo"},   32'(bus.SCLO),     32'd1);
        check({tag, "_end_ok"}, 32'(bus.END_OK),   32'd1);
        check({tag, "_ack_ok"}, 32'(bus.ACK_OK),   32'd0);
        check({tag, "_nack"},   32'(bus.NACK_ERR), 32'd0);
        check({tag, "_cnt"},    32'(bus.BYTE_CNT), 32'(cnt));
    endtask

    // Bus monitor and slave: collects bytes on SCL rising edges, detects
    // START/STOP, and drives SDAI high through the ACK slot of byte nack_byte.
    initial begin
        logic ps, pd, s, d, ack_phase;
        logic [7:0] sh;
        int bitcnt;
        ps = 1'b1; pd = 1'b1; ack_phase = 1'b0; sh = '0; bitcnt = 0;
        bus.SDAI = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            s = bus.SCLO;
            d = bus.SDAO;
            if (!rst_n) begin
                bitcnt    = 0;
                ack_phase = 1'b0;
                bus.SDAI  = 1'b0;
            end else if (ps && s && pd && !d) begin
                bitcnt = 0;
            end else if (ps && s && !pd && d) begin
                stops++;
                bitcnt = 0;
            end else if (!ps && s) begin
                if (bitcnt < 8) begin
                    sh = {sh[6:0], d};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        byte_q.push_back(sh);
                        bus.SDAI = (byte_q.size() == nack_byte);
                    end
                end else begin
                    bitcnt    = 0;
                    ack_phase = 1'b1;
                end
            end else if (ps && !s && ack_phase) begin
                ack_phase = 1'b0;
                bus.SDAI  = 1'b0;
            end
            ps = s;
            pd = d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dly, dur, n;
        bus.GO = 1'b0;
        bus.SLAVE_ADDRESS = '0;
        bus.POINTER = '0;
        bus.DATA = '0;
        bus.NBYTES = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 4'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // pointer-only burst, GO held high for 10 cycles
        byte_q.delete(); stops = 0; nack_byte = 0;
        start_burst(8'h80, 8'hE3, 32'h0, 3'd0, 10, dly);
        check("ptr_start_delay", dly, 1);
        wait_done(dur);
        check("ptr_cycles", dur, 77);
        check_bytes("ptr", 2, 48'h0000_0000_E380);
        check("ptr_ack_ok", 32'(bus.ACK_OK), 1);
        check("ptr_nack", 32'(bus.NACK_ERR), 0);
        check("ptr_cnt", 32'(bus.BYTE_CNT), 2);
        check("ptr_stops", stops, 1);

        // full burst with a GO pulse in the middle
        byte_q.delete(); stops = 0;
        start_burst(8'h80, 8'hE3, 32'hDDCCBBAA, 3'd4, 1, dly);
        check("full_start_delay", dly, 1);
        repeat (50) @(posedge clk);
        #1;
        check("full_busy", 32'(bus.END_OK), 0);
        bus.GO = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.GO = 1'b0;
        wait_done(dur);
        check("full_cycles", dur, 221);
        check_bytes("full", 6, 48'hDDCC_BBAA_E380);
        check("full_ack_ok", 32'(bus.ACK_OK), 1);
        check("full_cnt", 32'(bus.BYTE_CNT), 6);
        repeat (60) @(posedge clk);
        #1;
        check("gopulse_idle", 32'(bus.END_OK), 1);
        check("gopulse_nbytes", byte_q.size(), 6);
        check("gopulse_stops", stops, 1);

        // NACK on the pointer byte
        byte_q.delete(); stops = 0; nack_byte = 2;
        start_burst(8'h80, 8'hE3, 32'h12345678, 3'd4, 1, dly);
        wait_done(dur);
        nack_byte = 0;
        check("nack_cycles", dur, 77);
        check_bytes("nack", 2, 48'h0000_0000_E380);
        check("nack_err", 32'(bus.NACK_ERR), 1);
        check("nack_ack_ok", 32'(bus.ACK_OK), 0);
        check("nack_cnt", 32'(bus.BYTE_CNT), 1);
        check("nack_stops", stops, 1);

        // NBYTES above MAX_BYTES clamps
        byte_q.delete(); stops = 0;
        start_burst(8'h80, 8'hE3, 32'h44332211, 3'd7, 1, dly);
        wait_done(dur);
        check("clamp_cycles", dur, 221);
        check_bytes("clamp", 6, 48'h4433_2211_E380);
        check("clamp_ack_ok", 32'(bus.ACK_OK), 1);
        check("clamp_cnt", 32'(bus.BYTE_CNT), 6);

        // reset during the second payload byte
        byte_q.delete(); stops = 0;
        start_burst(8'h80, 8'hE3, 32'hDDCCBBAA, 3'd4, 1, dly);
        n = 0;
        while (byte_q.size() < 3 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_reached_byte", 32'(byte_q.size() >= 3), 1);
        repeat (10) @(posedge clk);
        #1;
        check("rst_pre_cnt", 32'(bus.BYTE_CNT), 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midrst", 4'd0);
        check("midrst_no_stop", stops, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // normal burst after the abandoned one
        byte_q.delete(); stops = 0;
        start_burst(8'h90, 8'h5A, 32'h0, 3'd1, 1, dly);
        check("after_start_delay", dly, 1);
        wait_done(dur);
        check("after_cycles", dur, 113);
        check_bytes("after", 3, 48'h0000_0000_5A90);
        check("after_ack_ok", 32'(bus.ACK_OK), 1);
        check("after_cnt", 32'(bus.BYTE_CNT), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_write_burst.md
# i2c_write_burst

Parametrised I2C master write engine, successor to the single-pointer write block in the humidity/temperature sensor path. One GO handshake sends START, the 8-bit slave address byte, a register pointer byte, then 0..MAX_BYTES data bytes, then STOP. Every byte's ACK is checked, and a NACK aborts the burst cleanly. Sits between the sensor-control sequencer and the open-drain pad logic, and is clocked by the same bit-phase tick PT_CK (four PT_CK cycles per SCL period).

## Interface
- MAX_BYTES, 4: maximum data bytes after the pointer (1..16).
- CW, $clog2(MAX_BYTES+1): width of NBYTES/BYTE_CNT.
- PT_CK  in  1  bit-phase clock; all logic on rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- GO  in  1  request level (handshake below).
- SLAVE_ADDRESS  in  8  address byte incl. R/W bit (bit 0 = 0 for write).
- POINTER  in  8  register pointer byte.
- DATA  in  8*MAX_BYTES  payload; byte k = DATA[8k+7:8k], byte 0 sent first, MSB first.
- NBYTES  in  CW  payload byte count; values > MAX_BYTES clamp to MAX_BYTES.
- SDAI  in  1  sampled SDA.
- SDAO  out  1  SDA drive (1 = release).
- SCLO  out  1  SCL drive (1 = release).
- END_OK  out  1  high = idle/complete; low while a burst runs.
- ACK_OK  out  1  high after a burst whose every byte was ACKed.
- NACK_ERR  out  1  high after a burst aborted by NACK.
- BYTE_CNT  out  CW+1  bytes transmitted in last/current burst (address and pointer included).

## Operation
- Reset (RESET_N low at PT_CK edge): state IDLE, SDAO=1, SCLO=1, END_OK=1, ACK_OK=0, NACK_ERR=0, BYTE_CNT=0. Mid-burst reset abandons the bus immediately, with no STOP.
- States: IDLE, ARM, START, B_LO, B_SET, B_HI, B_END, P0, P1, P2, DONE.
- IDLE: GO=1 -> ARM. ARM: GO=0 -> START. On this transition, latch SLAVE_ADDRESS, POINTER, DATA, and clamped NBYTES. Also set END_OK=0, ACK_OK=0, NACK_ERR=0, BYTE_CNT=0. GO staying high holds ARM.
- START: SDAO=0, SCLO=1 (START condition); load shifter with {address,1}.
- Per bit: B_LO SCLO=0; B_SET SDAO=shifter MSB, shift left; B_HI SCLO=1, bit counter+1; B_END SCLO=0.
  - Bits 1-8 are data. Bit 9 is ACK slot with SDAO=1.
  - In B_END of bit 9, SDAI is sampled.
- After ACK slot: SDAI=0 -> BYTE_CNT+1; if more bytes remain, load next byte ({pointer,1} then {DATA[k],1}) -> B_LO; else -> P0 with ACK_OK pending.
- SDAI=1 at ACK slot -> NACK_ERR=1, ACK_OK=0 -> P0 (remaining bytes skipped).
- Stop: P0 SDAO=0,SCLO=0; P1 SDAO=0,SCLO=1; P2 SDAO=1,SCLO=1.
- DONE: END_OK=1; ACK_OK=1 if no NACK occurred. Flags and BYTE_CNT hold until next ARM->START. -> IDLE.
- GO asserted during a burst is ignored; a new burst needs GO high in IDLE, then low.

## Timing
- ARM->START: 1 cycle after GO seen low.
- Per byte: 36 PT_CK cycles (9 bits x 4).
- Full burst, START entry to END_OK high: 1 + 36*(2+N) + 3 + 1 cycles. N=0: 77; N=4: 221.
- NACK on byte j (1-based): END_OK high 1 + 36*j + 4 cycles after START entry.
- SDAO changes only while SCLO=0, except START/STOP edges.

## Configuration
- I2C_WB_CLK_STRETCH_EN defined: adds input SCLI (1 bit). B_HI and P1 hold, with no counter advance, while SCLI=0 after SCLO released; timing above then becomes a minimum.
- Undefined: no SCLI port; fixed timing exactly as stated.

## Structure
- Shared package i2c_pkg: state enum, PH_PER_BIT=4, BITS_PER_BYTE=9 constants, NBYTES clamp function.
- One sub-module i2c_byte_tx: 9-bit shifter plus bit counter, with load/shift/done signals. The FSM in i2c_write_burst sequences bytes, START/STOP, and ACK checking.

## Test plan
- Pointer-only: SLAVE_ADDRESS=0x80, POINTER=0xE3, NBYTES=0, slave ACKs all -> bus bits 0x80,0xE3; ACK_OK=1, BYTE_CNT=2, END_OK high 77 cycles after START.
- Full burst: NBYTES=4, DATA=0xDDCCBBAA -> bytes 80,E3,AA,BB,CC,DD in order; ACK_OK=1, BYTE_CNT=6, 221 cycles.
- NACK on pointer byte (SDAI=1 in 2nd ACK slot) -> STOP issued, NACK_ERR=1, ACK_OK=0, BYTE_CNT=1, no data bits on bus.
- NBYTES=7 with MAX_BYTES=4 -> exactly 4 data bytes sent, BYTE_CNT=6.
- RESET_N low during data byte 2 -> next edge SDAO=1, SCLO=1, END_OK=1, flags 0; a new GO handshake then runs normally.
- GO held high 10 cycles, then low; GO pulsed mid-burst -> one burst only, starts 1 cycle after GO low, mid-burst pulse ignored.
